// File: rtl/apb_req_master_if.sv
// Request/response stream and APB4 bus bundle for apb_req_master.
// The master modport is the requester's view; slave is the environment side.
interface apb_req_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    req_write_i;
    logic [ADDR_WIDTH-1:0]   req_addr_i;
    logic [DATA_WIDTH-1:0]   req_wdata_i;
    logic [DATA_WIDTH/8-1:0] req_strb_i;

    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [DATA_WIDTH-1:0]   rsp_rdata_o;
    logic                    rsp_err_o;
    logic                    rsp_timeout_o;

    logic                    psel_o;
    logic                    penable_o;
    logic [ADDR_WIDTH-1:0]   paddr_o;
    logic                    pwrite_o;
    logic [DATA_WIDTH-1:0]   pwdata_o;
    logic [DATA_WIDTH/8-1:0] pstrb_o;
    logic                    pready_i;
    logic [DATA_WIDTH-1:0]   prdata_i;
    logic                    pslverr_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i,
        input  rsp_ready_i, pready_i, prdata_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i,
        output rsp_ready_i, pready_i, prdata_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, pstrb_o
    );
endinterface

// File: rtl/apb_req_master.sv
// APB4 requester: one valid/ready request becomes one APB transfer,
// with the result returned on a valid/ready response stream.
module apb_req_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic            clk_i,
    input logic            arst_ni,
    apb_req_master_if.master bus
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]         pstrb_q, pstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  to_q, to_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         wait_inc;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        to_d     = to_q;
        cnt_d    = cnt_q;
        wait_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i && req_ready_q) begin
                    state_d  = SETUP;
                    paddr_d  = bus.req_addr_i;
                    pwrite_d = bus.req_write_i;
                    pwdata_d = bus.req_wdata_i;
                    pstrb_d  = bus.req_write_i ? bus.req_strb_i : '0;
                    cnt_d    = '0;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (bus.pready_i) begin
                    state_d = RESP;
                    rdata_d = pwrite_q ? '0 : bus.prdata_i;
                    err_d   = bus.pslverr_i;
                    to_d    = 1'b0;
                end else if (TIMEOUT_CYCLES > 0 && wait_inc == CNT_LIM) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    cnt_d   = wait_inc;
                end else begin
                    cnt_d   = wait_inc;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Every visible control bit is a decode of the next state, then registered.
        req_ready_d = (state_d == IDLE);
        psel_d      = (state_d == SETUP) || (state_d == ACCESS);
        penable_d   = (state_d == ACCESS);
        rsp_valid_d = (state_d == RESP);
        if (!psel_d) pstrb_d = '0;
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            to_q        <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            to_q        <= to_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req_ready_o   = req_ready_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_rdata_o   = rdata_q;
    assign bus.rsp_err_o     = err_q;
    assign bus.rsp_timeout_o = to_q;
    assign bus.psel_o        = psel_q;
    assign bus.penable_o     = penable_q;
    assign bus.paddr_o       = paddr_q;
    assign bus.pwrite_o      = pwrite_q;
    assign bus.pwdata_o      = pwdata_q;
    assign bus.pstrb_o       = pstrb_q;
endmodule

// File: tb/tb_apb_req_master.sv
// Randomised scoreboard bench for apb_req_master with an APB slave model
// and a transaction-level reference model (TIMEOUT_CYCLES=8).
module tb_apb_req_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk;
    logic arst_ni;
    int   cyc;
    int   checks;
    int   errors;

    apb_req_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_req_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .arst_ni(arst_ni), .bus(bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;
        logic        perr;
        logic [31:0] prdata;
    } txn_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          acc;
        int          en;
    } rsp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [3:0]  strb;
        int          en;
    } apb_exp_t;

    txn_t     plan_q[$];
    rsp_exp_t rsp_q[$];
    apb_exp_t apb_q[$];

    int stall_left;
    bit always_rdy;
    int hs_cyc;
    bit hs_valid;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Transfer-level outcome: a slave that stalls TO or more cycles is cut off.
    function automatic void model(input txn_t t, output rsp_exp_t r, output apb_exp_t a);
        a.addr  = t.addr;
        a.wdata = t.wdata;
        a.wr    = t.wr;
        a.strb  = t.wr ? t.strb : 4'h0;
        if (t.waits >= TO) begin
            r.rdata = 0; r.err = 1; r.to = 1; a.en = TO;
        end else begin
            r.rdata = t.wr ? 32'h0 : t.prdata;
            r.err = t.perr; r.to = 0; a.en = t.waits + 1;
        end
        r.en  = a.en;
        r.acc = 0;
    endfunction

    function automatic txn_t mk(logic wr, logic [31:0] addr, logic [31:0] wd,
                                logic [3:0] strb, int waits, logic perr,
                                logic [31:0] rd);
        txn_t t;
        t.wr = wr; t.addr = addr; t.wdata = wd; t.strb = strb;
        t.waits = waits; t.perr = perr; t.prdata = rd;
        return t;
    endfunction

    task automatic send(input txn_t t);
        bit waited;
        int n;
        rsp_exp_t r;
        apb_exp_t a;
        @(negedge clk);
        bus.req_valid_i = 1;
        bus.req_write_i = t.wr;
        bus.req_addr_i  = t.addr;
        bus.req_wdata_i = t.wdata;
        bus.req_strb_i  = t.strb;
        waited = 0;
        n = 0;
        while (!bus.req_ready_o && n < 300) begin
            @(negedge clk);
            waited = 1;
            n++;
        end
        if (!bus.req_ready_o) begin
            chk("req_accept_bound", 0, 1);
            bus.req_valid_i = 0;
            return;
        end
        model(t, r, a);
        r.acc = cyc + 1;
        rsp_q.push_back(r);
        apb_q.push_back(a);
        plan_q.push_back(t);
        if (waited && hs_valid) chk("accept_after_rsp_hs", cyc + 1, hs_cyc + 1);
        @(posedge clk);
        #1;
        bus.req_valid_i = 0;
        bus.req_wdata_i = $urandom;
        bus.req_addr_i  = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (rsp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", rsp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // APB slave: stalls for the planned number of wait states, noise elsewhere.
    txn_t cur;
    int   k;
    always @(negedge clk) begin
        if (!arst_ni) begin
            k = 0;
            bus.pready_i  = 0;
            bus.prdata_i  = 0;
            bus.pslverr_i = 0;
        end else if (bus.psel_o && !bus.penable_o) begin
            if (plan_q.size() != 0) cur = plan_q.pop_front();
            k = 0;
            bus.pready_i  = 1'($urandom);
            bus.prdata_i  = $urandom;
            bus.pslverr_i = 1'($urandom);
        end else if (bus.psel_o && bus.penable_o) begin
            if (k == cur.waits) begin
                bus.pready_i  = 1;
                bus.prdata_i  = cur.prdata;
                bus.pslverr_i = cur.perr;
            end else begin
                bus.pready_i  = 0;
                bus.prdata_i  = $urandom;
                bus.pslverr_i = 1'($urandom);
            end
            k++;
        end else begin
            bus.pready_i  = 1'($urandom);
            bus.prdata_i  = $urandom;
            bus.pslverr_i = 1'($urandom);
        end
    end

    // APB-side monitor.
    apb_exp_t ca;
    int  en_cnt;
    bit  in_xfer;
    bit  prev_psel;
    always @(negedge clk) begin
        if (!arst_ni) begin
            en_cnt = 0; in_xfer = 0; prev_psel = 0;
        end else begin
            if (!bus.psel_o) begin
                chk("idle_penable", bus.penable_o, 0);
                chk("idle_pstrb", bus.pstrb_o, 0);
                if (in_xfer) begin
                    chk("penable_cycles", en_cnt, ca.en);
                    in_xfer = 0;
                end
            end else if (!bus.penable_o) begin
                chk("setup_after_idle", prev_psel, 0);
                if (apb_q.size() == 0) begin
                    chk("unexpected_setup", 1, 0);
                end else begin
                    ca = apb_q.pop_front();
                    chk("setup_paddr", bus.paddr_o, ca.addr);
                    chk("setup_pwrite", bus.pwrite_o, ca.wr);
                    chk("setup_pwdata", bus.pwdata_o, ca.wdata);
                    chk("setup_pstrb", bus.pstrb_o, ca.strb);
                    in_xfer = 1;
                    en_cnt = 0;
                end
            end else begin
                en_cnt++;
                chk("access_paddr", bus.paddr_o, ca.addr);
                chk("access_pstrb", bus.pstrb_o, ca.strb);
            end
            prev_psel = bus.psel_o;
        end
    end

    // Response monitor: drives rsp_ready and pops the scoreboard on handshake.
    bit prev_v;
    bit rdy;
    rsp_exp_t e;
    always @(negedge clk) begin
        if (!arst_ni) begin
            prev_v = 0;
            hs_valid = 0;
            bus.rsp_ready_i = 0;
        end else if (bus.rsp_valid_o) begin
            chk("resp_req_ready", bus.req_ready_o, 0);
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
                bus.rsp_ready_i = 1;
            end else begin
                e = rsp_q[0];
                if (!prev_v) chk("rsp_latency", cyc - e.acc, e.en + 1);
                chk("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                chk("rsp_err", bus.rsp_err_o, e.err);
                chk("rsp_timeout", bus.rsp_timeout_o, e.to);
                if (stall_left > 0) begin
                    rdy = 0;
                    stall_left--;
                end else begin
                    rdy = always_rdy ? 1'b1 : ($urandom % 3 != 0);
                end
                bus.rsp_ready_i = rdy;
                if (rdy) begin
                    void'(rsp_q.pop_front());
                    hs_cyc = cyc + 1;
                    hs_valid = 1;
                end
                prev_v = !rdy;
            end
        end else begin
            prev_v = 0;
            bus.rsp_ready_i = 1'($urandom);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        txn_t t;
        int   n;
        checks = 0; errors = 0; cyc = 0;
        stall_left = 0; always_rdy = 1;
        bus.req_valid_i = 0; bus.req_write_i = 0;
        bus.req_addr_i = 0; bus.req_wdata_i = 0; bus.req_strb_i = 0;
        arst_ni = 1;
        #3 arst_ni = 0;
        #1;
        chk("rst_psel", bus.psel_o, 0);
        chk("rst_penable", bus.penable_o, 0);
        chk("rst_req_ready", bus.req_ready_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        chk("rst_rsp_err", bus.rsp_err_o, 0);
        chk("rst_rsp_timeout", bus.rsp_timeout_o, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata_o, 0);
        chk("rst_pstrb", bus.pstrb_o, 0);
        chk("rst_paddr", bus.paddr_o, 0);
        repeat (2) @(negedge clk);
        #2 arst_ni = 1;
        @(negedge clk);
        chk("post_rst_req_ready", bus.req_ready_o, 1);

        send(mk(1, 32'h10, 32'hA5A5_1234, 4'hF, 0, 0, 32'h0));
        drain();
        send(mk(0, 32'h04, 32'h1111_2222, 4'hF, 3, 0, 32'hDEAD_BEEF));
        drain();
        send(mk(1, 32'h20, 32'h0BAD_F00D, 4'h3, 1, 1, 32'h0));
        send(mk(0, 32'h24, 32'h0, 4'h0, 0, 0, 32'h1234_5678));
        drain();
        send(mk(0, 32'h40, 32'h0, 4'hF, 20, 0, 32'hFFFF_FFFF));
        drain();

        // Response back-pressure with the next request already waiting.
        stall_left = 5;
        send(mk(1, 32'h50, 32'hCAFE_0001, 4'h5, 0, 0, 32'h0));
        send(mk(0, 32'h54, 32'h0, 4'hF, 0, 0, 32'h7777_8888));
        drain();

        for (int i = 0; i < 4; i++)
            send(mk(i[0], 32'h100 + 4 * i, $urandom, 4'($urandom), 0, 0, $urandom));
        drain();

        always_rdy = 0;
        for (int i = 0; i < 60; i++) begin
            t = mk(1'($urandom), $urandom, $urandom, 4'($urandom),
                   $urandom_range(0, 10), ($urandom % 4 == 0), $urandom);
            send(t);
            if ($urandom % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();

        // Asynchronous reset while the slave is stalling in ACCESS.
        always_rdy = 1;
        send(mk(0, 32'h80, 32'h0, 4'hF, 6, 0, 32'h5555_AAAA));
        n = 0;
        while (!(bus.psel_o && bus.penable_o) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_access", bus.psel_o && bus.penable_o, 1);
        @(negedge clk);
        #2 arst_ni = 0;
        #1;
        chk("midrst_psel", bus.psel_o, 0);
        chk("midrst_penable", bus.penable_o, 0);
        chk("midrst_rsp_valid", bus.rsp_valid_o, 0);
        rsp_q.delete();
        apb_q.delete();
        plan_q.delete();
        @(negedge clk);
        #2 arst_ni = 1;
        @(negedge clk);
        chk("midrst_req_ready", bus.req_ready_o, 1);
        send(mk(0, 32'h84, 32'h0, 4'hF, 2, 0, 32'h1357_9BDF));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
